// File: rtl/edge_evt_pkg.sv
// Shared constants for the edge-event arbiter: event type codes, control FSM states
// and synchronizer depth. EDGE_ARB_SYNC_EN selects the synchronized-input build.
package edge_evt_pkg;

    localparam logic RISE = 1'b1;
    localparam logic FALL = 1'b0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

    localparam int SYNC_STAGES = 2;

    // Clock edges spent in INIT before prev is loaded (the synchronizer must fill first).
`ifdef EDGE_ARB_SYNC_EN
    localparam int INIT_WAIT = SYNC_STAGES;
`else
    localparam int INIT_WAIT = 0;
`endif

endpackage

// File: rtl/edge_evt_chan.sv
// One level channel: optional input synchronizer (EDGE_ARB_SYNC_EN), edge detection,
// a single pending-event slot with its type, and a sticky overflow flag.
module edge_evt_chan
    import edge_evt_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic rise_en,
    input  logic fall_en,
    input  logic load,
    input  logic run,
    input  logic grant,
    input  logic clr,
    output logic pend,
    output logic typ,
    output logic ovf
);

    logic lvl_eff;
    logic prev;
    logic rise;
    logic fall;
    logic hit;
    logic ovf_set;

`ifdef EDGE_ARB_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], level};
        end
    end

    assign lvl_eff = sync_q[SYNC_STAGES-1];
`else
    assign lvl_eff = level;
`endif

    assign rise    = run & lvl_eff & ~prev & rise_en;
    assign fall    = run & ~lvl_eff & prev & fall_en;
    assign hit     = rise | fall;
    // A new edge collides only when the old event is not leaving this cycle.
    assign ovf_set = hit & pend & ~grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
            pend <= 1'b0;
            typ  <= FALL;
            ovf  <= 1'b0;
        end else begin
            if (load || run) begin
                prev <= lvl_eff;
            end
            if (grant) begin
                pend <= hit;
                typ  <= rise ? RISE : FALL;
            end else if (hit && !pend) begin
                pend <= 1'b1;
                typ  <= rise ? RISE : FALL;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel edge detectors feed a round-robin
// scheduler driving one valid/ready event output. EDGE_ARB_SYNC_EN adds input synchronizers.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] level,
    input  logic [N_CH-1:0] cfg_rise_en,
    input  logic [N_CH-1:0] cfg_fall_en,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [CH_W-1:0] ev_ch,
    output logic            ev_rising,
    output logic [N_CH-1:0] ovf,
    input  logic [N_CH-1:0] ovf_clr
);

    ctrl_state_t     state;
    logic [1:0]      init_cnt;
    logic            load;
    logic            run;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] typ;
    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] idx;
    logic            found;
    logic            slot_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == 2'(INIT_WAIT)) begin
                        state <= ST_RUN;
                    end else begin
                        init_cnt <= init_cnt + 2'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign load = (state == ST_INIT) && (init_cnt == 2'(INIT_WAIT));
    assign run  = (state == ST_RUN);

    // Output slot may take a new event when empty or when its event leaves this edge.
    assign slot_free = !ev_valid || ev_ready;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            int c;
            c = int'(rr_ptr) + k;
            if (c >= N_CH) begin
                c = c - N_CH;
            end
            if (!found && pend[c]) begin
                found = 1'b1;
                idx   = CH_W'(c);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (slot_free && found) begin
            grant[idx] = 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_evt_chan u_chan (
            .clk     (clk),
            .reset   (reset),
            .level   (level[i]),
            .rise_en (cfg_rise_en[i]),
            .fall_en (cfg_fall_en[i]),
            .load    (load),
            .run     (run),
            .grant   (grant[i]),
            .clr     (ovf_clr[i]),
            .pend    (pend[i]),
            .typ     (typ[i]),
            .ovf     (ovf[i])
        );
    end

    // Valid/ready: ev_ch/ev_rising only change when the slot is free, so they stay
    // stable while ev_valid && !ev_ready, and ev_valid drops only after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_valid  <= 1'b0;
            ev_ch     <= '0;
            ev_rising <= 1'b0;
            rr_ptr    <= CH_W'(N_CH - 1);
        end else if (slot_free && found) begin
            ev_valid  <= 1'b1;
            ev_ch     <= idx;
            ev_rising <= typ[idx];
            rr_ptr    <= idx;
        end else if (ev_valid && ev_ready) begin
            ev_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter against an event-level reference model.
module tb_edge_event_arbiter;

    localparam int N_CH = 4;
    localparam int CH_W = 2;
`ifdef EDGE_ARB_SYNC_EN
    localparam int WAIT = 2;
`else
    localparam int WAIT = 0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] level = '0;
    logic [N_CH-1:0] cfg_rise_en = '1;
    logic [N_CH-1:0] cfg_fall_en = '1;
    logic            ev_valid;
    logic            ev_ready = 1'b1;
    logic [CH_W-1:0] ev_ch;
    logic            ev_rising;
    logic [N_CH-1:0] ovf;
    logic [N_CH-1:0] ovf_clr = '0;

    int checks = 0;
    int failures = 0;

    edge_event_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .level       (level),
        .cfg_rise_en (cfg_rise_en),
        .cfg_fall_en (cfg_fall_en),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_ch       (ev_ch),
        .ev_rising   (ev_rising),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: one pending slot per channel, one output slot, round-robin pointer.
    bit            m_prev[N_CH];
    bit            m_pend[N_CH];
    bit            m_typ[N_CH];
    bit            m_s1[N_CH];
    bit            m_s2[N_CH];
    bit [N_CH-1:0] m_ovf;
    bit            m_valid;
    bit            m_rise;
    int            m_ch;
    int            m_rr;
    int            m_phase;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_prev[i] = 0; m_pend[i] = 0; m_typ[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
        end
        m_ovf = '0; m_valid = 0; m_rise = 0; m_ch = 0; m_rr = N_CH - 1; m_phase = 0;
    endtask

    task automatic model_step();
        bit eff[N_CH];
        bit running, loading, got_typ;
        bit [N_CH-1:0] set_ovf;
        int gi;
        running = (m_phase > WAIT);
        loading = (m_phase == WAIT);
        set_ovf = '0;
        for (int i = 0; i < N_CH; i++) eff[i] = (WAIT > 0) ? m_s2[i] : level[i];
        gi = -1;
        if (!m_valid || ev_ready) begin
            for (int k = 1; k <= N_CH; k++) begin
                int c;
                c = (m_rr + k) % N_CH;
                if (gi < 0 && m_pend[c]) gi = c;
            end
        end
        got_typ = (gi >= 0) ? m_typ[gi] : 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            bit r, f;
            r = running && eff[i] && !m_prev[i] && cfg_rise_en[i];
            f = running && !eff[i] && m_prev[i] && cfg_fall_en[i];
            if (i == gi) begin
                m_pend[i] = r || f;
                m_typ[i]  = r;
            end else if (r || f) begin
                if (m_pend[i]) set_ovf[i] = 1;
                else begin
                    m_pend[i] = 1;
                    m_typ[i]  = r;
                end
            end
            if (running || loading) m_prev[i] = eff[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = level[i];
        end
        m_ovf = (m_ovf & ~ovf_clr) | set_ovf;
        if (gi >= 0) begin
            m_valid = 1; m_ch = gi; m_rise = got_typ; m_rr = gi;
        end else if (m_valid && ev_ready) begin
            m_valid = 0;
        end
        if (m_phase <= WAIT) m_phase++;
    endtask

    // Advances n clock edges; inputs set by the caller are applied at the next edge.
    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("ev_valid", ev_valid, m_valid);
            check("ev_ch", ev_ch, m_ch);
            check("ev_rising", ev_rising, m_rise);
            check("ovf", ovf, m_ovf);
            ovf_clr = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_ch", ev_ch, 0);
        check("rst_ovf", ovf, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        level = 4'b0101; cfg_rise_en = 4'hf; cfg_fall_en = 4'hf; ev_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tick(20);

        // single rising edge on channel 2
        level = 4'b0111;
        tick(4);

        // park the pointer on ch0, then ch0/1/3 rise together
        cfg_fall_en = 4'b1101; level = 4'b0100;
        tick(4);
        cfg_fall_en = 4'hf; level = 4'b1111;
        tick(6);

        // overflow on ch1 while the consumer stalls, then drain and clear
        ev_ready = 1'b0; level = 4'b1101;
        tick(2);
        level = 4'b1111;
        tick(2);
        level = 4'b1101;
        tick(2);
        ev_ready = 1'b1;
        tick(4);
        ovf_clr = 4'b0010;
        tick(2);

        // falling edges masked on ch3
        cfg_fall_en = 4'b0111; level = 4'b0101;
        tick(2);
        level = 4'b1101;
        tick(4);
        cfg_fall_en = 4'hf;

        // reset with an event presented and several pending
        ev_ready = 1'b0; level = 4'b0000;
        tick(2);
        level = 4'b0010;
        tick(2);
        do_reset();
        ev_ready = 1'b1;
        tick(10);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 2) == 0) level = level ^ N_CH'($urandom_range(0, 15));
            ev_ready = ($urandom_range(0, 3) != 0);
            if (cyc % 50 == 0) begin
                cfg_rise_en = N_CH'($urandom_range(0, 15));
                cfg_fall_en = N_CH'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) ovf_clr = N_CH'($urandom_range(0, 15));
            if (cyc == 1500) do_reset();
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel edge-event controller. It watches N_CH level inputs and detects rising and/or falling edges per channel, under per-channel configuration.
- Each channel holds at most one pending event.
- Pending events are shared onto one output event channel through a round-robin scheduler with a valid/ready handshake.
- Sits between raw level sources (buttons, status lines) and a single event consumer, e.g. an interrupt or log FSM.

Parameters:
- N_CH, 4, number of level input channels (2..16).
- CH_W, 2, width of the channel index; must equal ceil(log2(N_CH)).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- level  in  N_CH  level inputs, one bit per channel; synchronous to clk unless the optional feature is enabled.
- cfg_rise_en  in  N_CH  per-channel enable for rising-edge events.
- cfg_fall_en  in  N_CH  per-channel enable for falling-edge events.
- ev_valid  out  1  an event is presented on ev_ch/ev_rising.
- ev_ready  in  1  consumer accepts the event when ev_valid && ev_ready at a clk edge.
- ev_ch  out  CH_W  channel index of the presented event.
- ev_rising  out  1  1 = rising-edge event, 0 = falling-edge event.
- ovf  out  N_CH  sticky per-channel overflow flags.
- ovf_clr  in  N_CH  per-bit clear of ovf, single-cycle pulse.

Behaviour:
- Reset values (asynchronous reset): ev_valid=0, ev_ch=0, ev_rising=0, ovf=0, all pending=0, all prev=0, rr pointer=N_CH-1, control FSM=INIT.
- Control FSM:
  - INIT: first clk edge after reset deassertion. Loads prev[i]<=level[i] for all channels, detects no edges, then goes to RUN.
  - RUN: normal operation; stays in RUN until reset.
  - Consequence: a line already high at reset release produces no event.
- Edge detect in RUN, per channel i:
  - rise_i = level[i] & ~prev[i] & cfg_rise_en[i]
  - fall_i = ~level[i] & prev[i] & cfg_fall_en[i]
  - prev[i]<=level[i] every RUN cycle, regardless of enables.
- Pending per channel: pend[i] and type typ[i] (1=rise).
  - An edge with pend[i]=0 sets pend[i]=1 and typ[i]=rise_i.
  - An edge with pend[i]=1 that is not granted this cycle: the new event is dropped, the older event is kept, and ovf[i]<=1.
  - An edge in the same cycle that channel i is granted: pend reloads with the new event. No overflow.
- Grant condition: a grant is possible when ev_valid==0, or ev_valid && ev_ready (back-to-back transfers allowed, no bubble).
- Grant selection: the first channel with pend=1, searching rr_ptr+1, rr_ptr+2, … modulo N_CH. On grant:
  - ev_valid<=1, ev_ch<=idx, ev_rising<=typ[idx].
  - pend[idx] clears unless reloaded.
  - rr_ptr<=idx.
- No grant possible, or nothing pending:
  - ev_valid<=0 if the current event was accepted.
  - Otherwise ev_valid and the event fields hold stable.
- Handshake rule: while ev_valid && !ev_ready, ev_ch and ev_rising must not change. ev_valid never drops without acceptance.
- Latency: level changes before clk edge t → pend set at t → ev_valid=1 after t+1, provided the output slot is free.
- Config changes affect only future edges. Already-pending events remain and are still delivered.
- ovf_clr[i] clears ovf[i]. If a set and a clear hit the same cycle, set wins.
- Reset mid-operation: all state returns to reset values immediately; pending events are lost; INIT is re-entered.

Optional Feature:
- Macro: EDGE_ARB_SYNC_EN.
- Defined: each level bit passes through a 2-flop synchronizer (reset to 0) before edge detection. Edge-to-valid latency grows by 2 cycles. INIT is held until the synchronizer has been loaded for 2 cycles, i.e. prev is loaded from the synchronized value on the 3rd clk edge after reset release.
- Undefined: level feeds edge detection directly, as described above.

Decomposition:
- Package edge_evt_pkg: RISE/FALL type constants; control FSM state encodings ST_INIT, ST_RUN; synchronizer depth constant SYNC_STAGES=2.
- Sub-module edge_evt_chan, instantiated N_CH times. Holds per-channel synchronizer (optional), prev, pend, typ and ovf. Inputs: run, grant, clr. Outputs: pend, typ.
- Top level holds the FSM, the round-robin arbiter and the output register.

Test Plan:
- Reset release with level=4'b0101 held, all cfg enables=1 → no ev_valid for 20 cycles; ovf=0.
- level[2] 0→1 with cfg_rise_en[2]=1 and ev_ready=1 → ev_valid=1, ev_ch=2, ev_rising=1 two edges later, for exactly one cycle.
- level[0], [1] and [3] all rise in the same cycle, ev_ready=1, rr_ptr=0 → events delivered on consecutive cycles, order 1, 3, 0.
- ev_ready=0; channel 1 pending; second edge (fall) on ch1 → ovf[1]=1. Then ev_ready=1 → exactly one event, ch1 rising. Then ovf_clr[1] pulse → ovf[1]=0.
- cfg_fall_en=0, cfg_rise_en=1 on ch3; toggle level[3] 1→0→1 → only one event, ev_rising=1.
- Reset asserted while ev_valid=1 and 3 events pending → ev_valid=0 immediately (asynchronous); after release, no stale events.
